// File: rtl/kernel_scheduler.sv
// Round-robin job dispatcher: one staging register feeds up to KERNEL_NUM kernel slots.
// Optional per-kernel watchdog is compiled in with `define KERNEL_SCHED_TIMEOUT_EN.
module kernel_scheduler #(
  parameter int unsigned KERNEL_NUM     = 8,
  parameter int unsigned DESC_WIDTH     = 512,
  parameter int unsigned TIMEOUT_CYCLES = 1048576
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  job_valid,
  output logic                  job_ready,
  input  logic [DESC_WIDTH-1:0] job_desc,
  input  logic                  job_last,
  output logic [KERNEL_NUM-1:0] kernel_start,
  output logic [DESC_WIDTH-1:0] system_register,
  input  logic [KERNEL_NUM-1:0] kernel_complete,
  output logic [KERNEL_NUM-1:0] kernel_busy,
  output logic                  real_done,
  output logic                  spurious_err,
  output logic [KERNEL_NUM-1:0] timeout_err
);

  localparam int unsigned LG_W = (KERNEL_NUM > 1) ? $clog2(KERNEL_NUM) : 1;

  if (KERNEL_NUM < 2 || KERNEL_NUM > 8 || DESC_WIDTH < 32 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
    $error("kernel_scheduler: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t                state, state_next;
  logic                  stage_full;
  logic                  stage_last;
  logic [DESC_WIDTH-1:0] stage_desc;
  logic [LG_W-1:0]       last_grant;
  logic [LG_W-1:0]       grant;
  logic [KERNEL_NUM-1:0] idle;
  logic [KERNEL_NUM-1:0] start_vec;
  logic                  dispatch;
  logic                  accept;

  // First idle kernel at or after last_grant+1, wrapping.
  function automatic logic [LG_W-1:0] rr_pick(input logic [LG_W-1:0]       last,
                                              input logic [KERNEL_NUM-1:0] free);
    logic [LG_W-1:0] pick;
    logic            hit;
    int unsigned     idx;
    pick = last;
    hit  = 1'b0;
    idx  = 0;
    for (int unsigned i = 0; i < KERNEL_NUM; i++) begin
      idx = (32'(last) + 32'd1 + i) % KERNEL_NUM;
      if (!hit && free[LG_W'(idx)]) begin
        pick = LG_W'(idx);
        hit  = 1'b1;
      end
    end
    return pick;
  endfunction

  assign idle      = ~kernel_busy;
  assign dispatch  = stage_full & (|idle);
  assign grant     = rr_pick(last_grant, idle);
  assign start_vec = dispatch ? (KERNEL_NUM'(1) << grant) : '0;

  // A dispatching stage refills in the same cycle, except behind the final job of a run.
  assign job_ready = !rst && (state == RUN || state == FINISH) &&
                     (!stage_full || (dispatch && !stage_last));
  assign accept    = job_valid & job_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (dispatch && stage_last) state_next = DRAIN;
      DRAIN:   if (!stage_full && kernel_busy == '0) state_next = FINISH;
      FINISH:  if (accept) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage_full      <= 1'b0;
      stage_last      <= 1'b0;
      stage_desc      <= '0;
      last_grant      <= LG_W'(KERNEL_NUM - 1);
      kernel_start    <= '0;
      system_register <= '0;
      kernel_busy     <= '0;
      spurious_err    <= 1'b0;
      real_done       <= 1'b0;
    end else begin
      if (accept) begin
        stage_full <= 1'b1;
        stage_desc <= job_desc;
        stage_last <= job_last;
      end else if (dispatch) begin
        stage_full <= 1'b0;
      end
      kernel_start <= start_vec;
      if (dispatch) begin
        system_register <= stage_desc;
        last_grant      <= grant;
      end
      // Completions on idle kernels are masked off by the busy term and only flagged.
      kernel_busy <= (kernel_busy & ~kernel_complete) | start_vec;
      if (|(kernel_complete & ~kernel_busy)) spurious_err <= 1'b1;
      real_done <= (state_next == FINISH);
    end
  end

`ifdef KERNEL_SCHED_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  for (genvar k = 0; k < KERNEL_NUM; k++) begin : g_wd
    logic [CNT_W-1:0] cnt;
    logic             flag;

    // Saturating busy-cycle counter; the flag is sticky and does not free the kernel.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt  <= '0;
        flag <= 1'b0;
      end else if (start_vec[k]) begin
        cnt <= '0;
      end else if (kernel_busy[k] && cnt != CNT_W'(TIMEOUT_CYCLES)) begin
        cnt <= cnt + CNT_W'(1);
        if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) flag <= 1'b1;
      end
    end

    assign timeout_err[k] = flag;
  end
`else
  assign timeout_err = '0;
`endif

endmodule

// File: tb/tb_kernel_scheduler.sv
// Directed bench for kernel_scheduler: dispatch order, back-pressure, round-robin,
// run completion, spurious completions, reset and the optional watchdog.
module tb_kernel_scheduler;

  localparam int unsigned KN = 8;
  localparam int unsigned DW = 64;

  logic          clk;
  logic          rst;
  logic          job_valid;
  logic          job_ready;
  logic [DW-1:0] job_desc;
  logic          job_last;
  logic [KN-1:0] kernel_start;
  logic [DW-1:0] system_register;
  logic [KN-1:0] kernel_complete;
  logic [KN-1:0] kernel_busy;
  logic          real_done;
  logic          spurious_err;
  logic [KN-1:0] timeout_err;

  int checks   = 0;
  int failures = 0;

  logic [DW-1:0] d [16];

  kernel_scheduler #(
    .KERNEL_NUM    (KN),
    .DESC_WIDTH    (DW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .job_valid      (job_valid),
    .job_ready      (job_ready),
    .job_desc       (job_desc),
    .job_last       (job_last),
    .kernel_start   (kernel_start),
    .system_register(system_register),
    .kernel_complete(kernel_complete),
    .kernel_busy    (kernel_busy),
    .real_done      (real_done),
    .spurious_err   (spurious_err),
    .timeout_err    (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) d[i] = {32'hCAFE_0000 + 32'(i), 24'(i * 7 + 1), 8'h5A};

    rst             = 1'b1;
    job_valid       = 1'b0;
    job_desc        = '0;
    job_last        = 1'b0;
    kernel_complete = '0;
    step();
    step();

    // reset values
    check("rst_ready", 64'(job_ready), 64'h0);
    check("rst_start", 64'(kernel_start), 64'h0);
    check("rst_busy", 64'(kernel_busy), 64'h0);
    check("rst_sysreg", 64'(system_register), 64'h0);
    check("rst_done", 64'(real_done), 64'h0);
    check("rst_spur", 64'(spurious_err), 64'h0);
    check("rst_tout", 64'(timeout_err), 64'h0);
    rst = 1'b0;
    #1;
    check("first_ready", 64'(job_ready), 64'h1);

    // three back-to-back jobs
    job_valid = 1'b1; job_desc = d[0];
    step();
    check("a_start0", 64'(kernel_start), 64'h00);
    job_desc = d[1];
    step();
    check("a_start1", 64'(kernel_start), 64'h01);
    check("a_sys1", 64'(system_register), d[0]);
    job_desc = d[2];
    step();
    check("a_start2", 64'(kernel_start), 64'h02);
    check("a_sys2", 64'(system_register), d[1]);
    job_valid = 1'b0;
    step();
    check("a_start3", 64'(kernel_start), 64'h04);
    check("a_sys3", 64'(system_register), d[2]);
    step();
    check("a_idle", 64'(kernel_start), 64'h00);
    check("a_busy", 64'(kernel_busy), 64'h07);

    // fill remaining kernels, ninth job stays staged
    for (int i = 3; i <= 8; i++) begin
      job_valid = 1'b1; job_desc = d[i];
      check($sformatf("b_ready%0d", i), 64'(job_ready), 64'h1);
      step();
    end
    job_valid = 1'b0;
    check("b_start7", 64'(kernel_start), 64'h80);
    check("b_sys7", 64'(system_register), d[7]);
    check("b_busy_full", 64'(kernel_busy), 64'hFF);
    check("b_ready_full", 64'(job_ready), 64'h0);
    step();
    check("b_hold_start", 64'(kernel_start), 64'h00);
    check("b_hold_ready", 64'(job_ready), 64'h0);
    kernel_complete = 8'h08;
    step();
    kernel_complete = '0;
    check("b_free3_busy", 64'(kernel_busy), 64'hF7);
    check("b_free3_start", 64'(kernel_start), 64'h00);
    step();
    check("b_restart3", 64'(kernel_start), 64'h08);
    check("b_restart3_sys", 64'(system_register), d[8]);
    check("b_busy_again", 64'(kernel_busy), 64'hFF);

    // round-robin wrap: last grant 5, kernels 2 and 7 idle
    kernel_complete = 8'h20;
    step();
    kernel_complete = '0;
    check("c_busy_df", 64'(kernel_busy), 64'hDF);
    job_valid = 1'b1; job_desc = d[9];
    step();
    job_valid = 1'b0;
    step();
    check("c_start5", 64'(kernel_start), 64'h20);
    kernel_complete = 8'h84;
    step();
    kernel_complete = '0;
    check("c_busy_7b", 64'(kernel_busy), 64'h7B);
    job_valid = 1'b1; job_desc = d[10];
    step();
    job_desc = d[11];
    step();
    check("c_start7", 64'(kernel_start), 64'h80);
    check("c_sys7", 64'(system_register), d[10]);
    job_valid = 1'b0;
    step();
    check("c_start2", 64'(kernel_start), 64'h04);
    check("c_sys2", 64'(system_register), d[11]);
    check("c_busy_ff", 64'(kernel_busy), 64'hFF);

    // reset mid-run discards staged job and busy state
    job_valid = 1'b1; job_desc = d[12];
    step();
    job_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("r_busy", 64'(kernel_busy), 64'h00);
    check("r_start", 64'(kernel_start), 64'h00);
    check("r_sys", 64'(system_register), 64'h0);
    check("r_ready", 64'(job_ready), 64'h0);
    check("r_tout", 64'(timeout_err), 64'h0);
    step();
    rst = 1'b0;
    step();
    check("r_nostart1", 64'(kernel_start), 64'h00);
    step();
    check("r_nostart2", 64'(kernel_start), 64'h00);
    check("r_busy_after", 64'(kernel_busy), 64'h00);

    // spurious completion is sticky until reset
    kernel_complete = 8'h10;
    step();
    kernel_complete = '0;
    check("s_spur", 64'(spurious_err), 64'h1);
    check("s_busy", 64'(kernel_busy), 64'h00);
    step();
    step();
    check("s_sticky", 64'(spurious_err), 64'h1);
    rst = 1'b1;
    step();
    check("s_rst_clear", 64'(spurious_err), 64'h0);
    rst = 1'b0;
    step();

    // run completion with job_last
    job_valid = 1'b1; job_desc = d[13]; job_last = 1'b0;
    step();
    job_desc = d[14]; job_last = 1'b1;
    step();
    check("d_start0", 64'(kernel_start), 64'h01);
    job_valid = 1'b0; job_last = 1'b0;
    step();
    check("d_start1", 64'(kernel_start), 64'h02);
    check("d_drain_ready", 64'(job_ready), 64'h0);
    check("d_done0", 64'(real_done), 64'h0);
    step();
    check("d_done1", 64'(real_done), 64'h0);
    check("d_busy3", 64'(kernel_busy), 64'h03);
    kernel_complete = 8'h01;
    step();
    kernel_complete = '0;
    check("d_busy2", 64'(kernel_busy), 64'h02);
    check("d_done2", 64'(real_done), 64'h0);
    kernel_complete = 8'h02;
    step();
    kernel_complete = '0;
    check("d_busy0", 64'(kernel_busy), 64'h00);
    check("d_done3", 64'(real_done), 64'h0);
    step();
    check("d_done_set", 64'(real_done), 64'h1);
    check("d_finish_ready", 64'(job_ready), 64'h1);
    step();
    check("d_done_hold", 64'(real_done), 64'h1);
    job_valid = 1'b1; job_desc = d[15];
    step();
    job_valid = 1'b0;
    check("d_done_clr", 64'(real_done), 64'h0);
    step();
    check("d_next_start", 64'(kernel_start), 64'h04);
    check("d_next_sys", 64'(system_register), d[15]);

    // watchdog
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    job_valid = 1'b1; job_desc = d[0];
    step();
    job_valid = 1'b0;
    step();
    check("t_start", 64'(kernel_start), 64'h01);
`ifdef KERNEL_SCHED_TIMEOUT_EN
    repeat (15) step();
    check("t_before", 64'(timeout_err), 64'h00);
    step();
    check("t_fire", 64'(timeout_err), 64'h01);
    check("t_still_busy", 64'(kernel_busy), 64'h01);
`else
    repeat (16) step();
    check("t_off", 64'(timeout_err), 64'h00);
    check("t_still_busy", 64'(kernel_busy), 64'h01);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
